// File: rtl/div_pkg.sv
// Shared types and helpers for the divide requester: op encodings, FSM states
// and an XLEN-agnostic conditional two's complement negation.
package div_pkg;

    localparam int DIV_XLEN_DEF = 32;
    localparam int DIV_TAGW_DEF = 5;
    localparam int DIV_NEG_W    = 128;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } div_req_state_t;

    // Callers zero-extend into DIV_NEG_W and truncate back; low bits equal modulo-2^XLEN negation.
    function automatic logic [DIV_NEG_W-1:0] cond_neg(input logic [DIV_NEG_W-1:0] value,
                                                      input logic                 neg);
        logic [DIV_NEG_W-1:0] result;
        if (neg) begin
            result = ~value + {{(DIV_NEG_W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic op_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_special_case.sv
// Detects requests that never need the divider (zero divisor, signed overflow)
// and produces their architectural result directly.
module div_special_case
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN_DEF
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            is_special,
    output logic [XLEN-1:0] special_result,
    output logic            divzero
);

    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_op_t op_s;
    logic    is_signed_s;
    logic    is_rem_s;
    logic    overflow_s;

    // Classify the request and pick the fixed result for each special case.
    always_comb begin
        op_s        = div_op_t'(op);
        is_signed_s = op_is_signed(op_s);
        is_rem_s    = op_is_rem(op_s);
        divzero     = (rs2 == ZERO);
        overflow_s  = is_signed_s && (rs1 == MIN_INT) && (rs2 == ONES);
        is_special  = divzero || overflow_s;
        if (divzero) begin
            special_result = is_rem_s ? rs1 : ONES;
        end else if (overflow_s) begin
            special_result = is_rem_s ? ZERO : rs1;
        end else begin
            special_result = ZERO;
        end
    end

endmodule

// File: rtl/div_requester.sv
// Initiator for the unsigned divider: folds signs into magnitudes, issues the
// divide, restores the sign of the selected result and returns it over valid/ready.
module div_requester
    import div_pkg::*;
#(
    parameter int XLEN = DIV_XLEN_DEF,
    parameter int TAGW = DIV_TAGW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [TAGW-1:0] req_tag,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [TAGW-1:0] resp_tag,
    output logic            resp_divzero,
    output logic            div_start,
    input  logic            div_ready,
    input  logic            div_valid,
    input  logic            div_error,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] value, input logic neg);
        return XLEN'(cond_neg(DIV_NEG_W'(value), neg));
    endfunction

    div_req_state_t state_q, state_d;
    div_op_t        op_q, op_d;
    div_op_t        req_op_s;
    logic [TAGW-1:0] tag_q, tag_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [TAGW-1:0] resp_tag_q, resp_tag_d;
    logic            resp_divzero_q, resp_divzero_d;
    logic            resp_valid_q, resp_valid_d;

    logic            sign1_s, sign2_s;
    logic            sp_is_special_s;
    logic [XLEN-1:0] sp_result_s;
    logic            sp_divzero_s;

    div_special_case #(.XLEN(XLEN)) u_special (
        .op             (req_op),
        .rs1            (req_rs1),
        .rs2            (req_rs2),
        .is_special     (sp_is_special_s),
        .special_result (sp_result_s),
        .divzero        (sp_divzero_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_DIV;
            tag_q          <= {TAGW{1'b0}};
            neg_quot_q     <= 1'b0;
            neg_rem_q      <= 1'b0;
            dividend_q     <= {XLEN{1'b0}};
            divisor_q      <= {XLEN{1'b0}};
            resp_data_q    <= {XLEN{1'b0}};
            resp_tag_q     <= {TAGW{1'b0}};
            resp_divzero_q <= 1'b0;
            resp_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            tag_q          <= tag_d;
            neg_quot_q     <= neg_quot_d;
            neg_rem_q      <= neg_rem_d;
            dividend_q     <= dividend_d;
            divisor_q      <= divisor_d;
            resp_data_q    <= resp_data_d;
            resp_tag_q     <= resp_tag_d;
            resp_divzero_q <= resp_divzero_d;
            resp_valid_q   <= resp_valid_d;
        end
    end

    // Next-state and datapath updates; flush outranks every other event.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        tag_d          = tag_q;
        neg_quot_d     = neg_quot_q;
        neg_rem_d      = neg_rem_q;
        dividend_d     = dividend_q;
        divisor_d      = divisor_q;
        resp_data_d    = resp_data_q;
        resp_tag_d     = resp_tag_q;
        resp_divzero_d = resp_divzero_q;
        req_op_s       = div_op_t'(req_op);
        sign1_s        = op_is_signed(req_op_s) && req_rs1[XLEN-1];
        sign2_s        = op_is_signed(req_op_s) && req_rs2[XLEN-1];

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (req_valid) begin
                    op_d       = req_op_s;
                    tag_d      = req_tag;
                    neg_quot_d = sign1_s ^ sign2_s;
                    neg_rem_d  = sign1_s;
                    dividend_d = neg_x(req_rs1, sign1_s);
                    divisor_d  = neg_x(req_rs2, sign2_s);
                    if (sp_is_special_s) begin
                        state_d        = ST_RESP;
                        resp_data_d    = sp_result_s;
                        resp_tag_d     = req_tag;
                        resp_divzero_d = sp_divzero_s;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_ready) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (div_valid) begin
                    state_d        = ST_RESP;
                    resp_tag_d     = tag_q;
                    resp_divzero_d = div_error;
                    if (op_is_rem(op_q)) begin
                        resp_data_d = neg_x(div_remainder, neg_rem_q);
                    end else begin
                        resp_data_d = neg_x(div_quotient, neg_quot_q);
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DRAIN: begin
                // The abandoned op's strobe must be swallowed before the divider is reused.
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (div_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        resp_valid_d = (state_d == ST_RESP);
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !flush;
        div_start = (state_q == ST_ISSUE);
    end

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_tag     = resp_tag_q;
    assign resp_divzero = resp_divzero_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_requester.sv
// Directed and randomized checks of div_requester against a RISC-V division
// reference model, with a behavioural unsigned divider that has no reset.
module tb_div_requester;

    localparam int XLEN = 32;
    localparam int TAGW = 5;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = 2'b00;
    logic [XLEN-1:0] req_rs1 = 32'd0;
    logic [XLEN-1:0] req_rs2 = 32'd0;
    logic [TAGW-1:0] req_tag = 5'd0;
    logic            flush = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic [XLEN-1:0] resp_data;
    logic [TAGW-1:0] resp_tag;
    logic            resp_divzero;
    logic            div_start;
    logic            div_ready;
    logic            div_valid;
    logic            div_error;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic [XLEN-1:0] div_quotient;
    logic [XLEN-1:0] div_remainder;

    int total = 0;
    int bad   = 0;

    div_requester #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_tag       (req_tag),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .resp_divzero  (resp_divzero),
        .div_start     (div_start),
        .div_ready     (div_ready),
        .div_valid     (div_valid),
        .div_error     (div_error),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    // Behavioural unsigned divider: no reset, fixed or random latency, one-cycle strobe.
    logic            m_busy = 1'b0;
    int              m_cnt = 0;
    int              lat_cfg = 0;
    logic [XLEN-1:0] m_a = 32'd0, m_b = 32'd0;
    logic            m_dv = 1'b0, m_err = 1'b0;
    logic [XLEN-1:0] m_q = 32'd0, m_r = 32'd0;
    int              starts = 0;
    logic [XLEN-1:0] last_dividend = 32'd0, last_divisor = 32'd0;

    assign div_ready     = !m_busy;
    assign div_valid     = m_dv;
    assign div_error     = m_err;
    assign div_quotient  = m_q;
    assign div_remainder = m_r;

    always @(posedge clk) begin
        m_dv <= 1'b0;
        if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                m_dv   <= 1'b1;
                m_err  <= (m_b == 32'd0);
                m_q    <= (m_b == 32'd0) ? 32'hFFFF_FFFF : m_a / m_b;
                m_r    <= (m_b == 32'd0) ? m_a : m_a % m_b;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (div_start) begin
            m_busy        <= 1'b1;
            m_a           <= div_dividend;
            m_b           <= div_divisor;
            last_dividend <= div_dividend;
            last_divisor  <= div_divisor;
            m_cnt         <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 6));
            starts        <= starts + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics using native signed/unsigned arithmetic.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] d, output logic dz, output logic sp,
                                      output logic [31:0] ua, output logic [31:0] ub);
        longint sa, sb;
        logic   sgn, rem;
        sgn = (op == OP_DIV) || (op == OP_REM);
        rem = op[1];
        sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        sp  = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        dz  = (b == 32'd0);
        if (b == 32'd0) begin
            d = rem ? a : 32'hFFFF_FFFF;
        end else if (sp) begin
            d = rem ? 32'd0 : a;
        end else begin
            d = rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        ua = 32'((sa < 0) ? -sa : sa);
        ub = 32'((sb < 0) ? -sb : sb);
    endfunction

    task automatic wait_req_ready();
        int w = 0;
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int hold);
        logic [31:0] exp_d, exp_ua, exp_ub;
        logic        exp_dz, exp_sp;
        int          st0, w;
        ref_model(op, a, b, exp_d, exp_dz, exp_sp, exp_ua, exp_ub);
        resp_ready = (hold == 0);
        wait_req_ready();
        st0       = starts;
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_sp) begin
            check("special_latency", 64'(resp_valid), 64'd1);
        end
        w = 0;
        while (!resp_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_data", 64'(resp_data), 64'(exp_d));
        check("resp_tag", 64'(resp_tag), 64'(tag));
        check("resp_divzero", 64'(resp_divzero), 64'(exp_dz));
        check("start_count", 64'(starts - st0), exp_sp ? 64'd0 : 64'd1);
        if (!exp_sp) begin
            check("div_dividend", 64'(last_dividend), 64'(exp_ua));
            check("div_divisor", 64'(last_divisor), 64'(exp_ub));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_data", 64'(resp_data), 64'(exp_d));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("resp_drop", 64'(resp_valid), 64'd0);
        check("back_idle", 64'(req_ready), 64'd1);
    endtask

    task automatic issue_and_wait_start(input logic [31:0] a, input logic [31:0] b);
        int st0, w;
        wait_req_ready();
        st0       = starts;
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (starts == st0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("start_seen", 64'(starts - st0), 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int saw;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);
        check("rst_resp_divzero", 64'(resp_divzero), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_dividend", 64'(div_dividend), 64'd0);

        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd3, 0);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd3, 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd4, 0);
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd5, 0);
        run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd6, 0);
        run_op(OP_DIV,  32'd5, 32'd0, 5'd7, 0);
        run_op(OP_REMU, 32'd5, 32'd0, 5'd8, 0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd12, 10);

        // Flush while the divider is working: its strobe must be drained silently.
        lat_cfg = 12;
        issue_and_wait_start(32'd1000, 32'd7);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("drain_req_ready", 64'(req_ready), 64'd0);
        saw = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid) saw = 1;
        end
        check("drain_no_resp", 64'(saw), 64'd0);
        lat_cfg = 0;
        run_op(OP_DIVU, 32'd9, 32'd3, 5'd13, 0);

        // Reset mid-divide: the old strobe arrives while the new op stalls in issue.
        lat_cfg = 12;
        issue_and_wait_start(32'd1000, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_resp_valid", 64'(resp_valid), 64'd0);
        check("rst2_req_ready", 64'(req_ready), 64'd1);
        check("rst2_resp_data", 64'(resp_data), 64'd0);
        lat_cfg = 3;
        run_op(OP_DIVU, 32'd9, 32'd3, 5'd14, 0);
        lat_cfg = 0;

        // Flush while a result is waiting for the consumer.
        resp_ready = 1'b0;
        wait_req_ready();
        req_valid = 1'b1;
        req_op    = OP_DIV;
        req_rs1   = 32'd5;
        req_rs2   = 32'd0;
        @(negedge clk);
        req_valid = 1'b0;
        check("resp_flush_pre", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", 64'(req_ready), 64'd0);
        flush = 1'b0;
        @(negedge clk);
        check("resp_flush_drop", 64'(resp_valid), 64'd0);
        check("resp_flush_idle", 64'(req_ready), 64'd1);
        resp_ready = 1'b1;

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom_range(0, 31)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_requester.md
Name: div_requester

Overview:
- Initiator side of the unsigned divider's start/ready/valid/error handshake.
- Accepts RISC-V M-extension divide ops (DIV/DIVU/REM/REMU) from the execute stage.
- Resolves signs and special cases locally, drives the unsigned divider, then returns a sign-corrected result over a valid/ready response channel.

Parameters:
XLEN, 32, operand/result width; the unsigned divider is instantiated externally with SIZE=XLEN.
TAGW, 5, width of the opaque tag (e.g. rd index) carried from request to response.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
req_rs1  in  XLEN  dividend
req_rs2  in  XLEN  divisor
req_tag  in  TAGW  opaque tag
flush  in  1  abandon any in-flight op
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_data  out  XLEN  quotient or remainder per op
resp_tag  out  TAGW  tag of the completed request
resp_divzero  out  1  divisor was zero
div_start  out  1  start pulse to divider
div_ready  in  1  divider idle
div_valid  in  1  divider result strobe (one cycle, no backpressure)
div_error  in  1  divider reported divide-by-zero
div_dividend  out  XLEN  unsigned dividend, held stable while div_start is high
div_divisor  out  XLEN  unsigned divisor, held stable while div_start is high
div_quotient  in  XLEN  unsigned quotient
div_remainder  in  XLEN  unsigned remainder

Behaviour:
- Reset (async, any state): state=IDLE; resp_valid=0, resp_data=0, resp_tag=0, resp_divzero=0, div_start=0, internal operands 0. req_ready=1 in the first cycle after reset.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- req_ready = (state==IDLE) && !flush. On accept, register op, tag, sign flags and absolute values.
  - Signed ops: abs(x)=x[XLEN-1] ? -x : x. abs(0x80..0)=0x80..0 is a valid unsigned value.
- IDLE→RESP (special case, divider not used), result registered one cycle after accept:
  - rs2==0: DIV/DIVU give all-ones; REM/REMU give rs1; resp_divzero=1.
  - Signed overflow (DIV/REM, rs1=0x80..0, rs2=all-ones): DIV gives rs1; REM gives 0; resp_divzero=0.
- IDLE→ISSUE: all other requests.
- ISSUE: div_start=1 (combinational from state) while in ISSUE. Move to WAIT in the cycle div_start && div_ready. div_start never asserts outside ISSUE.
- WAIT: on div_valid, select quotient (DIV/DIVU) or remainder (REM/REMU), then go to RESP.
  - Quotient is negated when the sign flags differ, signed ops only.
  - Remainder is negated when the dividend was negative, signed ops only.
  - resp_divzero=div_error. div_error is not expected, because zero divisors never reach the divider.
- RESP: resp_valid=1; data and tag held stable until resp_ready, then IDLE. Total non-special latency = divider latency + 3 cycles (accept, issue, capture).
- flush, which has priority over every other event in the same cycle:
  - IDLE/ISSUE/RESP: go to IDLE, drop any result, resp_valid falls next cycle.
  - WAIT: go to DRAIN.
  - DRAIN: wait for div_valid, discard it, go to IDLE. flush during DRAIN keeps DRAIN.
- Stale strobes: div_valid outside WAIT/DRAIN is ignored. This covers a strobe from an op started before reset, since the divider has no reset. In ISSUE, a busy divider (div_ready=0) simply stalls the issue.
- Width rule: all negation is two's complement modulo 2^XLEN. No extra result bits.

Decomposition:
- Package div_pkg holds:
  - div_op_t enum (DIV, DIVU, REM, REMU) with the encodings above.
  - div_req_state_t enum.
  - Helper function for XLEN-bit conditional negation.
- One natural sub-module, div_special_case (combinational): given op, rs1 and rs2, outputs is_special, special_result and divzero.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, tag=3 → one div_start with dividend 7, divisor 2; resp_data=0xFFFFFFFD, resp_tag=3, resp_divzero=0. REM with the same operands → 0xFFFFFFFF.
- DIVU 0xFFFFFFFF/0x10 → 0x0FFFFFFF; REMU → 0xF. REM 7 % -2 → 1.
- DIV 5/0 → 0xFFFFFFFF, resp_divzero=1, resp_valid 1 cycle after accept, no div_start. REMU 5/0 → 5.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, no div_start. REM with the same operands → 0.
- DIVU 100/7 with resp_ready low for 10 cycles → resp_valid and resp_data=14 stable, req_ready=0 throughout. resp_ready=1 → IDLE next cycle.
- flush in WAIT, then a new DIVU 9/3 → discarded strobe produces no resp_valid; next result is 3. Repeat with reset instead of flush (divider still busy) → stale div_valid ignored, subsequent op correct.
